spdot_bsr_sched: RTL and testbench

Block-sparse-row (BSR) job scheduler for the `spdot_bsr` compute core. It accepts one attention-tile job descriptor and walks the BSR index memory (`row_ptr` / `col_idx`). For every nonzero block it issues one start/done transaction to the core and folds the returned checksums into a 64-bit result. It sits between the command/CSR front end and a single `spdot_bsr` core instance, and owns the core's `start` and size inputs.

---
 rtl/spdot_pkg.sv | 24 ++
 rtl/spdot_wdog.sv | 33 +++
 rtl/spdot_bsr_sched.sv | 172 +++++++++++++++++
 tb/tb_spdot_bsr_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spdot_pkg.sv
// Shared types and constants for the spdot_bsr job scheduler.
package spdot_pkg;

  localparam int IDX_DW  = 16;
  localparam int CKSUM_W = 64;
  localparam int WDOG_W  = 20;
  localparam int unsigned TIMEOUT_DEF = 1048575;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_P0A  = 4'd1,
    ST_P0D  = 4'd2,
    ST_PEA  = 4'd3,
    ST_PED  = 4'd4,
    ST_CA   = 4'd5,
    ST_CD   = 4'd6,
    ST_ISS  = 4'd7,
    ST_WAIT = 4'd8,
    ST_SUM  = 4'd9,
    ST_NROW = 4'd10,
    ST_FIN  = 4'd11
  } sched_state_e;

endpackage

// File: rtl/spdot_wdog.sv
// Loadable down-counter watchdog; expire is asserted on the last enabled cycle of the window.
module spdot_wdog
  import spdot_pkg::*;
#(
  parameter int W = WDOG_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  // A load value of 0 or 1 expires on the first enabled cycle.
  assign expire = en && (cnt <= W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/spdot_bsr_sched.sv
// BSR job scheduler: walks row_ptr/col_idx, issues one core transaction per nonzero block
// and accumulates the returned checksums.
module spdot_bsr_sched
  import spdot_pkg::*;
#(
  parameter int          IDX_AW  = 10,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [IDX_DW-1:0]  cfg_n_brow,
  input  logic [IDX_AW-1:0]  cfg_col_base,
  input  logic [IDX_DW-1:0]  cfg_blk_size,
  input  logic [IDX_DW-1:0]  cfg_head_dim,
  input  logic               abort,
  output logic [IDX_AW-1:0]  idx_raddr,
  input  logic [IDX_DW-1:0]  idx_rdata,
  output logic               core_start,
  output logic [IDX_DW-1:0]  core_m_rows,
  output logic [IDX_DW-1:0]  core_s_tokens,
  output logic [IDX_DW-1:0]  core_head_dim,
  output logic [IDX_DW-1:0]  blk_row,
  output logic [IDX_DW-1:0]  blk_col,
  input  logic               core_done,
  input  logic [CKSUM_W-1:0] core_checksum,
  output logic               busy,
  output logic               done,
  output logic [CKSUM_W-1:0] result,
  output logic [IDX_DW-1:0]  blk_count,
  output logic               err,
  output logic               aborted
);

  localparam logic [WDOG_W-1:0] TO_LOAD = WDOG_W'(TIMEOUT);

  sched_state_e       state, state_next;
  logic [IDX_DW-1:0]  r, ptr, ptr_end, n_brow;
  logic [IDX_AW-1:0]  col_base;
  logic [CKSUM_W-1:0] cksum;
  logic               abort_pend, wdog_expire;
  logic               accept, illegal, abort_hit, ptr_more, row_more;

  assign accept    = cfg_valid && (state == ST_IDLE);
  assign illegal   = (cfg_blk_size == '0) || (cfg_head_dim == '0);
  assign abort_hit = abort && (state inside {ST_P0A, ST_P0D, ST_PEA, ST_PED,
                                             ST_CA, ST_CD, ST_ISS, ST_NROW});
  assign ptr_more  = ({1'b0, ptr} + 17'd1) < {1'b0, ptr_end};
  assign row_more  = ({1'b0, r} + 17'd1) < {1'b0, n_brow};
  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign blk_row   = r;

  always_comb begin
    idx_raddr = '0;
    case (state)
      ST_PEA:  idx_raddr = IDX_AW'(r + 16'd1);
      ST_CA:   idx_raddr = col_base + IDX_AW'(ptr);
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (illegal || cfg_n_brow == '0) ? ST_FIN : ST_P0A;
      ST_P0A:  state_next = ST_P0D;
      ST_P0D:  state_next = ST_PEA;
      ST_PEA:  state_next = ST_PED;
      // end <= ptr covers both an empty row and a malformed one
      ST_PED:  state_next = (idx_rdata <= ptr) ? ST_NROW : ST_CA;
      ST_CA:   state_next = ST_CD;
      ST_CD:   state_next = ST_ISS;
      ST_ISS:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (core_done)        state_next = ST_SUM;
        else if (wdog_expire) state_next = ST_FIN;
      end
      ST_SUM:  state_next = abort_pend ? ST_FIN : (ptr_more ? ST_CA : ST_NROW);
      ST_NROW: state_next = row_more ? ST_PEA : ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort_hit) state_next = ST_FIN;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      core_start <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      core_start <= (state_next == ST_ISS);
      done       <= (state == ST_FIN);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_brow        <= '0;
      col_base      <= '0;
      core_m_rows   <= '0;
      core_s_tokens <= '0;
      core_head_dim <= '0;
      r             <= '0;
      ptr           <= '0;
      ptr_end       <= '0;
      blk_col       <= '0;
      cksum         <= '0;
      result        <= '0;
      blk_count     <= '0;
      err           <= 1'b0;
      aborted       <= 1'b0;
      abort_pend    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          n_brow        <= cfg_n_brow;
          col_base      <= cfg_col_base;
          core_m_rows   <= cfg_blk_size;
          core_s_tokens <= cfg_blk_size;
          core_head_dim <= cfg_head_dim;
          r             <= '0;
          ptr           <= '0;
          ptr_end       <= '0;
          blk_col       <= '0;
          result        <= '0;
          blk_count     <= '0;
          err           <= illegal;
          aborted       <= 1'b0;
          abort_pend    <= 1'b0;
        end
        ST_P0D: ptr     <= idx_rdata;
        ST_PED: ptr_end <= idx_rdata;
        ST_CD:  blk_col <= idx_rdata;
        ST_WAIT: begin
          if (core_done)        cksum <= core_checksum;
          else if (wdog_expire) err   <= 1'b1;
          // the in-flight block is allowed to finish before the abort takes effect
          if (abort) abort_pend <= 1'b1;
        end
        ST_SUM: begin
          result    <= result + cksum;
          blk_count <= blk_count + 16'd1;
          ptr       <= ptr + 16'd1;
          if (abort_pend) aborted <= 1'b1;
        end
        ST_NROW: begin
          r   <= r + 16'd1;
          ptr <= ptr_end;
        end
        default: ;
      endcase
      if (abort_hit) aborted <= 1'b1;
    end
  end

  spdot_wdog #(
    .W(WDOG_W)
  ) u_wdog (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (accept),
    .load     (state == ST_ISS),
    .load_val (TO_LOAD),
    .en       (state == ST_WAIT),
    .expire   (wdog_expire)
  );

endmodule

// File: tb/tb_spdot_bsr_sched.sv
// Self-checking bench: table of BSR jobs with expected start coordinates and results,
// plus hand-written timeout, abort and mid-job reset sequences.
module tb_spdot_bsr_sched;

  localparam logic [9:0] COL_BASE = 10'd16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_n_brow = '0;
  logic [9:0]  cfg_col_base = '0;
  logic [15:0] cfg_blk_size = '0;
  logic [15:0] cfg_head_dim = '0;
  logic        abort = 1'b0;
  logic [9:0]  idx_raddr;
  logic [15:0] idx_rdata = '0;
  logic        core_start;
  logic [15:0] core_m_rows, core_s_tokens, core_head_dim, blk_row, blk_col;
  logic        core_done = 1'b0;
  logic [63:0] core_checksum = '0;
  logic        busy, done, err, aborted;
  logic [63:0] result;
  logic [15:0] blk_count;

  typedef struct packed {
    logic [15:0]      n_brow;
    logic [15:0]      blk;
    logic [15:0]      hd;
    logic [0:3][15:0] rp;
    logic [0:3][15:0] ci;
    logic [7:0]       n_exp;
    logic [0:3][15:0] er;
    logic [0:3][15:0] ec;
    logic [63:0]      res;
    logic [15:0]      cnt;
    logic             err;
  } job_t;

  job_t        jobs [0:6];
  logic [31:0] exp_q [$];
  logic [15:0] mem [0:1023];
  logic [15:0] cur_blk = '0, cur_hd = '0;
  int          errors = 0, checks = 0, job_starts = 0, cyc = 0;
  bit          no_resp = 1'b0;
  logic        prev_start = 1'b0;

  spdot_bsr_sched #(.IDX_AW(10), .TIMEOUT(50)) dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n_brow(cfg_n_brow), .cfg_col_base(cfg_col_base), .cfg_blk_size(cfg_blk_size),
    .cfg_head_dim(cfg_head_dim), .abort(abort), .idx_raddr(idx_raddr), .idx_rdata(idx_rdata),
    .core_start(core_start), .core_m_rows(core_m_rows), .core_s_tokens(core_s_tokens),
    .core_head_dim(core_head_dim), .blk_row(blk_row), .blk_col(blk_col),
    .core_done(core_done), .core_checksum(core_checksum), .busy(busy), .done(done),
    .result(result), .blk_count(blk_count), .err(err), .aborted(aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) idx_rdata <= mem[idx_raddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  // Core model: answers each start three cycles later with 100*(col+1).
  always begin : core_model
    logic [15:0] col;
    @(posedge clk); #1;
    if (core_start && !no_resp) begin
      col = blk_col;
      repeat (3) @(posedge clk);
      #1;
      core_checksum = 64'd100 * (64'(col) + 64'd1);
      core_done = 1'b1;
      @(posedge clk); #1;
      core_done = 1'b0;
    end
  end

  always begin : start_mon
    logic [31:0] e;
    @(posedge clk); #1;
    if (core_start) begin
      job_starts++;
      $display("start row=%0d col=%0d", blk_row, blk_col);
      chk("start_pulse_width", 64'(prev_start), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start got=(%0d,%0d) required=none", blk_row, blk_col);
      end else begin
        e = exp_q.pop_front();
        chk("start_coord", 64'({blk_row, blk_col}), 64'(e));
      end
      chk("start_m_rows", 64'(core_m_rows), 64'(cur_blk));
      chk("start_s_tokens", 64'(core_s_tokens), 64'(cur_blk));
      chk("start_head_dim", 64'(core_head_dim), 64'(cur_hd));
    end
    prev_start = core_start;
  end

  task automatic launch(input job_t j, input int n_push);
    for (int i = 0; i < 4; i++) begin
      mem[i] = j.rp[i];
      mem[int'(COL_BASE) + i] = j.ci[i];
    end
    cur_blk = j.blk;
    cur_hd  = j.hd;
    for (int i = 0; i < n_push; i++) exp_q.push_back({j.er[i], j.ec[i]});
    @(posedge clk); #1;
    cfg_n_brow   = j.n_brow;
    cfg_col_base = COL_BASE;
    cfg_blk_size = j.blk;
    cfg_head_dim = j.hd;
    cfg_valid    = 1'b1;
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    job_starts = 0;
    chk("ready_after_accept", 64'(cfg_ready), 64'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_wait got=no_done required=done_within_3000_cycles");
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (core_start !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (core_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL start_wait got=no_start required=start_within_200_cycles");
    end
  endtask

  task automatic check_end(input string tag, input logic [63:0] res, input logic [15:0] cnt,
                           input logic e, input logic a, input int nst);
    $display("job %s result=%0d count=%0d err=%0b aborted=%0b", tag, result, blk_count, err, aborted);
    chk({tag, "_result"}, result, res);
    chk({tag, "_blk_count"}, 64'(blk_count), 64'(cnt));
    chk({tag, "_err"}, 64'(err), 64'(e));
    chk({tag, "_aborted"}, 64'(aborted), 64'(a));
    chk({tag, "_ready_at_done"}, 64'(cfg_ready), 64'd1);
    chk({tag, "_starts"}, 64'(job_starts), 64'(nst));
    chk({tag, "_pending_starts"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    jobs[0] = '{n_brow:16'd2, blk:16'd8, hd:16'd4, rp:{16'd0, 16'd2, 16'd3, 16'd0},
                ci:{16'd1, 16'd3, 16'd0, 16'd0}, n_exp:8'd3, er:{16'd0, 16'd0, 16'd1, 16'd0},
                ec:{16'd1, 16'd3, 16'd0, 16'd0}, res:64'd700, cnt:16'd3, err:1'b0};
    jobs[1] = '{n_brow:16'd2, blk:16'd8, hd:16'd4, rp:{16'd0, 16'd0, 16'd1, 16'd0},
                ci:{16'd5, 16'd0, 16'd0, 16'd0}, n_exp:8'd1, er:{16'd1, 16'd0, 16'd0, 16'd0},
                ec:{16'd5, 16'd0, 16'd0, 16'd0}, res:64'd600, cnt:16'd1, err:1'b0};
    jobs[2] = '{n_brow:16'd2, blk:16'd8, hd:16'd0, rp:{16'd0, 16'd2, 16'd3, 16'd0},
                ci:{16'd1, 16'd3, 16'd0, 16'd0}, n_exp:8'd0, er:'0, ec:'0,
                res:64'd0, cnt:16'd0, err:1'b1};
    jobs[3] = '{n_brow:16'd0, blk:16'd8, hd:16'd4, rp:'0, ci:'0, n_exp:8'd0, er:'0, ec:'0,
                res:64'd0, cnt:16'd0, err:1'b0};
    // row 1 has end < ptr and must be skipped like an empty row
    jobs[4] = '{n_brow:16'd2, blk:16'd16, hd:16'd2, rp:{16'd0, 16'd2, 16'd1, 16'd0},
                ci:{16'd2, 16'd4, 16'd0, 16'd0}, n_exp:8'd2, er:{16'd0, 16'd0, 16'd0, 16'd0},
                ec:{16'd2, 16'd4, 16'd0, 16'd0}, res:64'd800, cnt:16'd2, err:1'b0};
    jobs[5] = '{n_brow:16'd2, blk:16'd0, hd:16'd4, rp:{16'd0, 16'd2, 16'd3, 16'd0},
                ci:{16'd1, 16'd3, 16'd0, 16'd0}, n_exp:8'd0, er:'0, ec:'0,
                res:64'd0, cnt:16'd0, err:1'b1};
    jobs[6] = '{n_brow:16'd3, blk:16'd4, hd:16'd8, rp:{16'd0, 16'd1, 16'd1, 16'd1},
                ci:{16'd7, 16'd0, 16'd0, 16'd0}, n_exp:8'd1, er:{16'd0, 16'd0, 16'd0, 16'd0},
                ec:{16'd7, 16'd0, 16'd0, 16'd0}, res:64'd800, cnt:16'd1, err:1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_blk_count", 64'(blk_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_core_m_rows", 64'(core_m_rows), 64'd0);
    chk("rst_idx_raddr", 64'(idx_raddr), 64'd0);
    rstn = 1'b1;

    for (int k = 0; k < 7; k++) begin
      launch(jobs[k], int'(jobs[k].n_exp));
      wait_done(cyc);
      // short jobs: FIN in the cycle after accept, done registered one cycle later
      if (jobs[k].n_brow == 16'd0 || jobs[k].blk == 16'd0 || jobs[k].hd == 16'd0)
        chk($sformatf("t%0d_fin_latency", k), 64'(cyc), 64'd1);
      check_end($sformatf("t%0d", k), jobs[k].res, jobs[k].cnt, jobs[k].err, 1'b0,
                int'(jobs[k].n_exp));
    end

    // Timeout: ISS, 50 WAIT cycles, FIN, then the done cycle.
    no_resp = 1'b1;
    launch(jobs[1], 1);
    wait_start();
    wait_done(cyc);
    chk("timeout_latency", 64'(cyc), 64'd52);
    check_end("timeout", 64'd0, 16'd0, 1'b1, 1'b0, 1);
    no_resp = 1'b0;

    // Abort during WAIT of the first of three blocks.
    launch(jobs[0], 1);
    wait_start();
    @(posedge clk); #1;
    abort = 1'b1;
    wait_done(cyc);
    abort = 1'b0;
    check_end("abort", 64'd200, 16'd1, 1'b0, 1'b1, 1);

    // Reset in WAIT; the old block's done arrives while idle and must be ignored.
    launch(jobs[0], 1);
    wait_start();
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("midrst_core_start", 64'(core_start), 64'd0);
    chk("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_blk_count", 64'(blk_count), 64'd0);
    chk("midrst_blk_col", 64'(blk_col), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    launch(jobs[0], 3);
    wait_done(cyc);
    check_end("after_reset", 64'd700, 16'd3, 1'b0, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
